// File: rtl/regbank_rr_arbiter.sv
// Round-robin write controller that shares one register-bank write port among NUM_REQ requesters.
// Optional write-lock support (lock_mask / wr_err) is enabled by defining REGBANK_WRLOCK_EN.
module regbank_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
`ifdef REGBANK_WRLOCK_EN
  input  logic [NUM_REGS-1:0]          lock_mask,
  output logic                         wr_err,
`endif
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REGS-1:0]          reg_en,
  output logic [DATA_W-1:0]            reg_d,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0]  r_req_ready, w_ready_nxt;
  logic [NUM_REGS-1:0] r_reg_en, w_en_nxt;
  logic [DATA_W-1:0]   r_reg_d, w_d_nxt;
  logic [ID_W-1:0]     r_grant_id, w_gid_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_found;
  logic [ID_W-1:0]     w_win;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;
  logic [NUM_REQ-1:0]  w_win_onehot;
  logic [NUM_REGS-1:0] w_hit;

`ifdef REGBANK_WRLOCK_EN
  logic                r_wr_err, w_err_nxt;
`endif

  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned k);
    int unsigned s;
    s = base + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // First valid requester at or above the pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[wrap_idx(32'(r_ptr), k)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(wrap_idx(32'(r_ptr), k));
      end
    end
  end

  assign w_win_addr = req_addr[32'(w_win) * ADDR_W +: ADDR_W];
  assign w_win_data = req_data[32'(w_win) * DATA_W +: DATA_W];

  // Out-of-range addresses decode to an all-zero enable
  always_comb begin
    w_hit        = '0;
    w_win_onehot = '0;
    for (int unsigned j = 0; j < NUM_REGS; j++) begin
      w_hit[j] = (w_win_addr == ADDR_W'(j));
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_win_onehot[i] = (w_win == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ready_nxt = r_req_ready;
    w_en_nxt    = r_reg_en;
    w_d_nxt     = r_reg_d;
    w_gid_nxt   = r_grant_id;
    w_busy_nxt  = r_busy;
`ifdef REGBANK_WRLOCK_EN
    w_err_nxt   = r_wr_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = '0;
        w_en_nxt    = '0;
        w_busy_nxt  = 1'b0;
`ifdef REGBANK_WRLOCK_EN
        w_err_nxt   = 1'b0;
`endif
        if (w_found) begin
          w_state_nxt = S_WRITE;
          w_ready_nxt = w_win_onehot;
          w_d_nxt     = w_win_data;
          w_gid_nxt   = w_win;
          w_busy_nxt  = 1'b1;
`ifdef REGBANK_WRLOCK_EN
          w_en_nxt    = w_hit & ~lock_mask;
          w_err_nxt   = ~(|w_hit) | (|(w_hit & lock_mask));
`else
          w_en_nxt    = w_hit;
`endif
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = '0;
        w_en_nxt    = '0;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
`ifdef REGBANK_WRLOCK_EN
        w_err_nxt   = 1'b0;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_req_ready <= '0;
      r_reg_en    <= '0;
      r_reg_d     <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_req_ready <= w_ready_nxt;
      r_reg_en    <= w_en_nxt;
      r_reg_d     <= w_d_nxt;
      r_grant_id  <= w_gid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef REGBANK_WRLOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wr_err <= 1'b0;
    else        r_wr_err <= w_err_nxt;
  end

  assign wr_err = r_wr_err;
`endif

  assign req_ready = r_req_ready;
  assign reg_en    = r_reg_en;
  assign reg_d     = r_reg_d;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Scoreboard bench for regbank_rr_arbiter with a behavioural register bank on reg_en/reg_d.
// Defining REGBANK_WRLOCK_EN also exercises the write-lock path.
module tb_regbank_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  reg_en;
  logic [3:0]  reg_d;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef REGBANK_WRLOCK_EN
  logic [3:0]  lock_mask;
  logic        wr_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // {req_ready, reg_en, reg_d, grant_id, busy, wr_err}
  logic [15:0] sb[$];
  logic [3:0]  bank [4];

  regbank_rr_arbiter #(.NUM_REQ(4), .NUM_REGS(4), .DATA_W(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef REGBANK_WRLOCK_EN
    .lock_mask (lock_mask),
    .wr_err    (wr_err),
`endif
    .req_ready (req_ready),
    .reg_en    (reg_en),
    .reg_d     (reg_d),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register bank fed by the controller
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) if (reg_en[j]) bank[j] <= reg_d;
  end

  function automatic logic [15:0] obs();
`ifdef REGBANK_WRLOCK_EN
    return {req_ready, reg_en, reg_d, grant_id, busy, wr_err};
`else
    return {req_ready, reg_en, reg_d, grant_id, busy, 1'b0};
`endif
  endfunction

  task automatic set_req(input int i, input logic [1:0] a, input logic [3:0] d);
    req_addr[i*2 +: 2] = a;
    req_data[i*4 +: 4] = d;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] o;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    reset     = 1'b0;
    @(negedge clk);
    o = obs();
    n_checks++;
    if (o !== 16'h0000) begin n_fails++; $display("FAIL reset_c1 act=%h exp=%h", o, 16'h0000); end
    repeat (2) @(negedge clk);
    o = obs();
    n_checks++;
    if (o !== 16'h0000) begin n_fails++; $display("FAIL reset_c3 act=%h exp=%h", o, 16'h0000); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    o = obs();
    n_checks++;
    if (o !== 16'h0000) begin n_fails++; $display("FAIL idle_no_req act=%h exp=%h", o, 16'h0000); end
  endtask

  task automatic test_single();
    bit got;
    logic [15:0] e, o;
    set_req(2, 2'd3, 4'hA);
    req_valid = 4'b0100;
    sb.push_back({4'b0100, 4'b1000, 4'hA, 2'd2, 1'b1, 1'b0});
    wait_grant(got);
    e = sb.pop_front();
    o = obs();
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL single timeout act=none exp=%h", e); end
    else if (o !== e) begin n_fails++; $display("FAIL single act=%h exp=%h", o, e); end
    req_valid = '0;
    @(negedge clk);
    o = obs();
    n_checks++;
    if (o !== {4'b0000, 4'b0000, 4'hA, 2'd2, 1'b0, 1'b0}) begin
      n_fails++; $display("FAIL single_after act=%h exp=%h", o, {4'b0000, 4'b0000, 4'hA, 2'd2, 1'b0, 1'b0});
    end
    n_checks++;
    if (bank[3] !== 4'hA) begin n_fails++; $display("FAIL single_bank3 act=%h exp=%h", bank[3], 4'hA); end
  endtask

  task automatic test_round_robin();
    bit got;
    logic [15:0] e, o;
    logic [4:0] p;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'(i + 1));
    req_valid = 4'b1111;
    sb.push_back({4'b0001, 4'b0001, 4'h1, 2'd0, 1'b1, 1'b0});
    sb.push_back({4'b0010, 4'b0010, 4'h2, 2'd1, 1'b1, 1'b0});
    sb.push_back({4'b0100, 4'b0100, 4'h3, 2'd2, 1'b1, 1'b0});
    sb.push_back({4'b1000, 4'b1000, 4'h4, 2'd3, 1'b1, 1'b0});
    sb.push_back({4'b0001, 4'b0001, 4'h1, 2'd0, 1'b1, 1'b0});
    for (int g = 0; g < 5; g++) begin
      wait_grant(got);
      e = sb.pop_front();
      o = obs();
      n_checks++;
      if (!got) begin n_fails++; $display("FAIL rr_grant%0d timeout act=none exp=%h", g, e); end
      else if (o !== e) begin n_fails++; $display("FAIL rr_grant%0d act=%h exp=%h", g, o, e); end
      if (g == 4) req_valid = '0;
      @(negedge clk);
      p = {req_ready, busy};
      n_checks++;
      if (p !== 5'b00000) begin n_fails++; $display("FAIL rr_pulse%0d act=%h exp=%h", g, p, 5'b00000); end
    end
  endtask

  task automatic test_wrap();
    bit got;
    logic [15:0] e, o;
    set_req(3, 2'd2, 4'hC);
    set_req(0, 2'd1, 4'h6);
    req_valid = 4'b1000;
    sb.push_back({4'b1000, 4'b0100, 4'hC, 2'd3, 1'b1, 1'b0});
    sb.push_back({4'b0001, 4'b0010, 4'h6, 2'd0, 1'b1, 1'b0});
    sb.push_back({4'b1000, 4'b0100, 4'hC, 2'd3, 1'b1, 1'b0});
    for (int g = 0; g < 3; g++) begin
      wait_grant(got);
      e = sb.pop_front();
      o = obs();
      n_checks++;
      if (!got) begin n_fails++; $display("FAIL wrap_grant%0d timeout act=none exp=%h", g, e); end
      else if (o !== e) begin n_fails++; $display("FAIL wrap_grant%0d act=%h exp=%h", g, o, e); end
      req_valid = (g == 2) ? 4'b0000 : 4'b1001;
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    bit got;
    logic [15:0] e, o;
    apply_reset();
    set_req(0, 2'd3, 4'h0);
    set_req(1, 2'd0, 4'h5);
    set_req(2, 2'd0, 4'h9);
    req_valid = 4'b0001;
    sb.push_back({4'b0001, 4'b1000, 4'h0, 2'd0, 1'b1, 1'b0});
    sb.push_back({4'b0010, 4'b0001, 4'h5, 2'd1, 1'b1, 1'b0});
    sb.push_back({4'b0100, 4'b0001, 4'h9, 2'd2, 1'b1, 1'b0});
    for (int g = 0; g < 3; g++) begin
      wait_grant(got);
      e = sb.pop_front();
      o = obs();
      n_checks++;
      if (!got) begin n_fails++; $display("FAIL coll_grant%0d timeout act=none exp=%h", g, e); end
      else if (o !== e) begin n_fails++; $display("FAIL coll_grant%0d act=%h exp=%h", g, o, e); end
      if (g == 2) begin
        n_checks++;
        if (bank[0] !== 4'h5) begin n_fails++; $display("FAIL coll_bank0_mid act=%h exp=%h", bank[0], 4'h5); end
      end
      req_valid = (g == 0) ? 4'b0110 : (g == 1) ? 4'b0100 : 4'b0000;
    end
    @(negedge clk);
    n_checks++;
    if (bank[0] !== 4'h9) begin n_fails++; $display("FAIL coll_bank0_final act=%h exp=%h", bank[0], 4'h9); end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [15:0] e, o;
    logic [3:0] prev;
    apply_reset();
    set_req(1, 2'd3, 4'h7);
    req_valid = 4'b0010;
    sb.push_back({4'b0010, 4'b1000, 4'h7, 2'd1, 1'b1, 1'b0});
    wait_grant(got);
    e = sb.pop_front();
    o = obs();
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL rmid_pre timeout act=none exp=%h", e); end
    else if (o !== e) begin n_fails++; $display("FAIL rmid_pre act=%h exp=%h", o, e); end
    prev = bank[1];
    set_req(2, 2'd1, 4'hD);
    req_valid = 4'b0100;
    sb.push_back({4'b0100, 4'b0010, 4'hD, 2'd2, 1'b1, 1'b0});
    wait_grant(got);
    e = sb.pop_front();
    o = obs();
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL rmid_write timeout act=none exp=%h", e); end
    else if (o !== e) begin n_fails++; $display("FAIL rmid_write act=%h exp=%h", o, e); end
    #1 reset = 1'b0;
    req_valid = '0;
    #1 o = obs();
    n_checks++;
    if (o !== 16'h0000) begin n_fails++; $display("FAIL rmid_async_clear act=%h exp=%h", o, 16'h0000); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bank[1] !== prev) begin n_fails++; $display("FAIL rmid_no_load act=%h exp=%h", bank[1], prev); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'(8 + i));
    req_valid = 4'b1111;
    sb.push_back({4'b0001, 4'b0001, 4'h8, 2'd0, 1'b1, 1'b0});
    wait_grant(got);
    e = sb.pop_front();
    o = obs();
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL rmid_ptr_restart timeout act=none exp=%h", e); end
    else if (o !== e) begin n_fails++; $display("FAIL rmid_ptr_restart act=%h exp=%h", o, e); end
    req_valid = '0;
    @(negedge clk);
  endtask

`ifdef REGBANK_WRLOCK_EN
  task automatic test_wrlock();
    bit got;
    logic [15:0] e, o;
    apply_reset();
    lock_mask = 4'b0100;
    set_req(0, 2'd2, 4'h3);
    set_req(1, 2'd1, 4'h4);
    req_valid = 4'b0001;
    sb.push_back({4'b0001, 4'b0000, 4'h3, 2'd0, 1'b1, 1'b1});
    sb.push_back({4'b0010, 4'b0010, 4'h4, 2'd1, 1'b1, 1'b0});
    for (int g = 0; g < 2; g++) begin
      wait_grant(got);
      e = sb.pop_front();
      o = obs();
      n_checks++;
      if (!got) begin n_fails++; $display("FAIL lock_grant%0d timeout act=none exp=%h", g, e); end
      else if (o !== e) begin n_fails++; $display("FAIL lock_grant%0d act=%h exp=%h", g, o, e); end
      req_valid = (g == 0) ? 4'b0010 : 4'b0000;
    end
    @(negedge clk);
    n_checks++;
    if (wr_err !== 1'b0) begin n_fails++; $display("FAIL lock_err_clear act=%b exp=%b", wr_err, 1'b0); end
  endtask
`endif

  initial begin
`ifdef REGBANK_WRLOCK_EN
    lock_mask = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_collision();
    test_reset_mid();
`ifdef REGBANK_WRLOCK_EN
    test_wrlock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regbank_rr_arbiter.md
Name: regbank_rr_arbiter

Overview:
Round-robin write controller that shares the write port of a bank of NUM_REGS DATA_W-bit enable-gated registers among NUM_REQ requesters. It latches one winning request, drives a one-hot register enable and shared data bus for one cycle, and acknowledges the winner. It sits between requester agents and the register bank instances, which have a d input, an enable, and are clocked by the same clk.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_REGS, 4, number of registers in the bank (1..2**ADDR_W)
DATA_W, 4, register data width
ADDR_W, 2, register address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-cycle acknowledge pulse to the winning requester
reg_en  output  NUM_REGS  one-hot register enable to the bank
reg_d  output  DATA_W  shared data to all bank d inputs
grant_id  output  $clog2(NUM_REQ)  index of the last or current winner
busy  output  1  high while in WRITE

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, rr pointer=0, req_ready=0, reg_en=0, reg_d=0, grant_id=0, busy=0.
- FSM has two states, all outputs registered:
  - IDLE: if any req_valid is high at the clock edge, select the winner: the first requester with valid high, searching from the rr pointer upward and wrapping modulo NUM_REQ.
  - On that edge, latch the winner's addr into addr_q and its data into data_q, set grant_id=winner, assert req_ready[winner]=1, set reg_d=data_q, and set reg_en one-hot at addr_q. Then go to WRITE. If no request is valid, stay in IDLE with all pulses at 0.
  - WRITE: this state lasts exactly one cycle, with busy=1. On exit, clear req_ready and reg_en, set pointer = (winner+1) mod NUM_REQ, and go to IDLE. reg_d and grant_id hold their values.
- Latency and throughput:
  - The edge that samples the request is followed by one cycle of reg_en/req_ready.
  - The bank captures data on the next edge, i.e. 2 edges after the request.
  - Sustained rate is 1 write per 2 cycles.
  - Requests are not sampled while in WRITE.
- Handshake: a requester holds valid/addr/data stable until it sees req_ready high, then drops valid or presents the next request. A request is committed once latched. Deasserting valid during WRITE does not cancel the write.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. Maximum wait is NUM_REQ grants.
- Out-of-range address (addr_q >= NUM_REGS): the request is acknowledged, reg_en stays all-zero, and no register changes.
- Same-address collisions are serialized by arbitration. The later grant overwrites the earlier one.
- If reset is asserted mid-WRITE, all outputs clear immediately (asynchronously) and no reg_en pulse survives. After release, the pointer restarts at 0.
- Only one reg_en bit and at most one req_ready bit are ever high.

Optional Feature:
Macro REGBANK_WRLOCK_EN.
- Defined:
  - Adds input lock_mask [NUM_REGS] and output wr_err [1].
  - lock_mask is sampled at the IDLE->WRITE edge. If lock_mask[addr_q] is high, reg_en is all-zero, req_ready still pulses, and wr_err=1 for that same WRITE cycle.
  - An out-of-range address also sets wr_err. wr_err resets to 0.
- Undefined: neither port exists, and writes are never suppressed except for out-of-range addresses.

Test Plan:
- Reset then single request: reset low 3 cycles, then high. req_valid=4'b0100, req_addr[2]=3, req_data[2]=4'hA -> one cycle later req_ready=4'b0100, reg_en=4'b1000, reg_d=A, grant_id=2, busy=1. Then IDLE.
- Round-robin: req_valid=4'b1111 held, all data distinct -> grants 0,1,2,3,0 on alternate cycles, each req_ready a one-cycle pulse.
- Pointer wrap: after a grant to 3, req_valid=4'b1001 -> next grant is 0. After that, with 4'b1001 still held, the next grant is 3.
- Collision: requesters 1 and 2 both write addr 0, with data 5 then 9, pointer=1 -> reg_en=4'b0001 twice; the bank's final register 0 value is 9.
- Reset mid-operation: assert reset during WRITE with reg_en=4'b0010 -> reg_en, req_ready and busy go to 0 before the next clk edge, and the register does not load.
- REGBANK_WRLOCK_EN build: lock_mask=4'b0100, write to addr 2 -> req_ready pulses, reg_en=0, wr_err=1 for one cycle. A write to addr 1 proceeds normally with wr_err=0.
